date_set_ctrl: RTL and testbench
================================

DATE_SET_CTRL -- requirements
Module: date_set_ctrl

Interface
REQ-001 Parameter: BLINK_DIV, 25, clk_out cycles per blink half-period; legal range 1..255.
REQ-002 clk_out  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick_day  input  1  single-cycle pulse from the hour counter at midnight carry.
REQ-005 btn_mode  input  1  debounced single-cycle pulse; advances the setting mode.
REQ-006 btn_up  input  1  debounced single-cycle pulse; increments the field being set.
REQ-007 month1  output  4  month tens digit, BCD, registered.
REQ-008 month0  output  4  month units digit, BCD, registered.
REQ-009 day1  output  4  day tens digit, BCD, registered.
REQ-010 day0  output  4  day units digit, BCD, registered.
REQ-011 mode  output  2  current FSM state encoding: 0 RUN, 1 SET_MONTH, 2 SET_DAY.
REQ-012 blink  output  1  display blink enable for the field being set; 0 in RUN.
REQ-013 year_inc  output  1  registered single-cycle pulse on the 12/31 to 01/01 rollover.

Function
REQ-014 The FSM SHALL have states RUN, SET_MONTH, SET_DAY; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-015 btn_mode SHALL advance RUN->SET_MONTH->SET_DAY->RUN, one step per pulse.
REQ-016 btn_mode and btn_up asserted in the same cycle: btn_mode SHALL take effect; btn_up SHALL be ignored.
REQ-017 Month day limits: 31 for 01,03,05,07,08,10,12; 30 for 04,06,09,11; 28 for 02 (no leap years).
REQ-018 RUN + tick_day, day < limit: day SHALL increment by 1 in BCD (x9 -> (x+1)0) on that edge.
REQ-019 RUN + tick_day, day == limit: day SHALL become 01 and month SHALL increment (09 -> 10 BCD).
REQ-020 RUN + tick_day at 12/31: date SHALL become 01/01, and year_inc SHALL be 1 for exactly the following cycle.
REQ-021 tick_day in SET_MONTH or SET_DAY SHALL be discarded; date unchanged; no year_inc.
REQ-022 SET_MONTH + btn_up: month SHALL increment 01..12 and wrap 12 -> 01 without a year_inc.
REQ-023 On the same edge as any month change (REQ-019, REQ-022), day SHALL clamp to min(day, limit of the new month).
REQ-024 SET_DAY + btn_up: day SHALL increment; at the limit it SHALL wrap to 01; the month SHALL be unchanged.
REQ-025 btn_up in RUN SHALL be ignored.
REQ-026 Blink counter SHALL count 0..BLINK_DIV-1 in set modes.
REQ-027 blink SHALL toggle when the counter wraps.
REQ-028 On entering any state, the blink counter SHALL clear and blink SHALL be 1 in set modes, 0 in RUN.
REQ-029 Outputs SHALL always hold a legal date: month 01..12; day 01..limit; every BCD digit <= 9.
REQ-030 Latency: every input pulse SHALL be reflected on the outputs at the next rising edge; there is no other pipelining.

Reset
REQ-031 rst_n low SHALL immediately force month 01, day 01, mode RUN, blink 0, year_inc 0 and blink counter 0, regardless of the clock.
REQ-032 Reset asserted mid-setting SHALL abandon the setting with no partial update retained; operation SHALL resume in RUN after release.
REQ-033 The first rising edge after rst_n rises SHALL process inputs normally.

Verification
REQ-034 Reset, 31 tick_day pulses -> date 02/01 after the 31st; 28 more -> 03/01; year_inc never asserted.
REQ-035 Preset 12/31 via set modes, return to RUN, one tick_day -> 01/01 and year_inc high exactly one cycle.
REQ-036 Set 01/31, SET_MONTH, one btn_up -> 02/28; btn_up x2 -> 04/28 (no further clamp); 12 -> 01 wrap gives no year_inc.
REQ-037 SET_DAY at 04/30, btn_up -> 04/01; btn_mode+btn_up in the same cycle -> mode RUN, day unchanged.
REQ-038 BLINK_DIV=4 in SET_MONTH -> blink pattern 1,1,1,1,0,0,0,0 from state entry; tick_day ignored; RUN -> blink 0.
REQ-039 Assert rst_n low between clock edges while in SET_DAY -> outputs 01/01, mode RUN immediately, before the next edge.

Source files
------------

// File: rtl/date_set_ctrl.sv
// rtl/date_set_ctrl.sv - month/day calendar with button-driven date setting and field blink
module date_set_ctrl #(
  parameter int unsigned BLINK_DIV = 25
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       tick_day,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] day1,
  output logic [3:0] day0,
  output logic [1:0] mode,
  output logic       blink,
  output logic       year_inc
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] SET_MONTH = 2'd1;
  localparam logic [1:0] SET_DAY   = 2'd2;
  localparam logic [7:0] BLINK_MAX = 8'(BLINK_DIV - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] blink_cnt;
  logic       entering, set_mode;
  logic [6:0] m_cur, d_cur, m_nxt, d_nxt, lim_cur, lim_nxt;
  logic       year_nxt;

  function automatic logic [6:0] month_limit(input logic [6:0] m);
    case (m)
      7'd2:                          month_limit = 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11:       month_limit = 7'd30;
      default:                       month_limit = 7'd31;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    to_bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // state register
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // next-state logic; the unused encoding falls back to RUN
  always_comb begin
    state_nxt = RUN;
    case (state)
      RUN:       state_nxt = btn_mode ? SET_MONTH : RUN;
      SET_MONTH: state_nxt = btn_mode ? SET_DAY   : SET_MONTH;
      SET_DAY:   state_nxt = btn_mode ? RUN       : SET_DAY;
      default:   state_nxt = RUN;
    endcase
  end

  // output decode
  always_comb begin
    mode     = state;
    set_mode = (state == SET_MONTH) || (state == SET_DAY);
    entering = (state_nxt != state);
  end

  // date datapath computed in binary, stored as BCD digits
  always_comb begin
    m_cur    = 7'(month1) * 7'd10 + 7'(month0);
    d_cur    = 7'(day1) * 7'd10 + 7'(day0);
    lim_cur  = month_limit(m_cur);
    m_nxt    = m_cur;
    d_nxt    = d_cur;
    year_nxt = 1'b0;
    case (state)
      RUN: begin
        if (tick_day) begin
          if (d_cur < lim_cur) begin
            d_nxt = d_cur + 7'd1;
          end else begin
            d_nxt = 7'd1;
            if (m_cur >= 7'd12) begin
              m_nxt    = 7'd1;
              year_nxt = 1'b1;
            end else begin
              m_nxt = m_cur + 7'd1;
            end
          end
        end
      end
      SET_MONTH: begin
        if (btn_up && !btn_mode) begin
          m_nxt = (m_cur >= 7'd12) ? 7'd1 : m_cur + 7'd1;
        end
      end
      SET_DAY: begin
        if (btn_up && !btn_mode) begin
          d_nxt = (d_cur >= lim_cur) ? 7'd1 : d_cur + 7'd1;
        end
      end
      default: ;
    endcase
    lim_nxt = month_limit(m_nxt);
    if (d_nxt > lim_nxt) d_nxt = lim_nxt;
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      month1   <= 4'd0;
      month0   <= 4'd1;
      day1     <= 4'd0;
      day0     <= 4'd1;
      year_inc <= 1'b0;
    end else begin
      {month1, month0} <= to_bcd(m_nxt);
      {day1, day0}     <= to_bcd(d_nxt);
      year_inc         <= year_nxt;
    end
  end

  // blink restarts high on entry to a set mode and toggles every BLINK_DIV cycles
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= 8'd0;
      blink     <= 1'b0;
    end else if (entering) begin
      blink_cnt <= 8'd0;
      blink     <= (state_nxt == SET_MONTH) || (state_nxt == SET_DAY);
    end else if (set_mode) begin
      if (blink_cnt >= BLINK_MAX) begin
        blink_cnt <= 8'd0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end else begin
      blink_cnt <= 8'd0;
      blink     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
// tb/tb_date_set_ctrl.sv - scoreboard bench for date_set_ctrl with directed and random stimulus
module tb_date_set_ctrl;

  localparam int DIV = 4;

  logic       clk_out = 1'b0;
  logic       rst_n;
  logic       tick_day, btn_mode, btn_up;
  logic [3:0] month1, month0, day1, day0;
  logic [1:0] mode;
  logic       blink, year_inc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int m;
    int d;
    int md;
    bit bl;
    bit yi;
  } exp_t;

  exp_t sb[$];

  // reference model: calendar date, mode and cycles since the last state entry
  int m_m, m_d, m_md, m_ent;

  date_set_ctrl #(.BLINK_DIV(DIV)) dut (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .tick_day(tick_day),
    .btn_mode(btn_mode),
    .btn_up  (btn_up),
    .month1  (month1),
    .month0  (month0),
    .day1    (day1),
    .day0    (day0),
    .mode    (mode),
    .blink   (blink),
    .year_inc(year_inc)
  );

  always #5 clk_out = ~clk_out;

  function automatic int days_in(input int m);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return tbl[m - 1];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_m = 1; m_d = 1; m_md = 0; m_ent = 0;
  endtask

  task automatic step(input bit t, input bit bm, input bit bu);
    exp_t e;
    @(negedge clk_out);
    tick_day = t; btn_mode = bm; btn_up = bu;
    e.yi = 1'b0;
    if (m_md == 0 && t) begin
      if (m_d < days_in(m_m)) m_d++;
      else begin
        m_d = 1;
        if (m_m == 12) begin m_m = 1; e.yi = 1'b1; end
        else m_m++;
      end
    end else if (m_md == 1 && bu && !bm) begin
      m_m = (m_m % 12) + 1;
      if (m_d > days_in(m_m)) m_d = days_in(m_m);
    end else if (m_md == 2 && bu && !bm) begin
      m_d = (m_d == days_in(m_m)) ? 1 : m_d + 1;
    end
    if (bm) begin m_md = (m_md + 1) % 3; m_ent = 0; end
    else m_ent++;
    e.m = m_m; e.d = m_d; e.md = m_md;
    e.bl = (m_md != 0) && ((m_ent / DIV) % 2 == 0);
    sb.push_back(e);
  endtask

  task automatic goto_mode(input int k);
    while (m_md != k) step(0, 1, 0);
  endtask

  task automatic set_date(input int tm, input int td);
    goto_mode(1);
    while (m_m != tm) step(0, 0, 1);
    goto_mode(2);
    while (m_d != td) step(0, 0, 1);
    goto_mode(0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_month1"}, month1, 0);
    chk({tag, "_month0"}, month0, 1);
    chk({tag, "_day1"}, day1, 0);
    chk({tag, "_day0"}, day0, 1);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_blink"}, blink, 0);
    chk({tag, "_year_inc"}, year_inc, 0);
  endtask

  // monitor: every cycle presents a full output word, compared after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_out);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("month1", month1, e.m / 10);
        chk("month0", month0, e.m % 10);
        chk("day1", day1, e.d / 10);
        chk("day0", day0, e.d % 10);
        chk("mode", mode, e.md);
        chk("blink", blink, e.bl);
        chk("year_inc", year_inc, e.yi);
      end
    end
  end

  initial begin
    rst_n = 1'b0; tick_day = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_out);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    // calendar advance through January and February
    repeat (31) step(1, 0, 0);
    repeat (28) step(1, 0, 0);

    // year rollover from 12/31
    set_date(12, 31);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    // month change clamps the day; 12 -> 01 wrap gives no year pulse
    set_date(1, 31);
    goto_mode(1);
    step(0, 0, 1);
    repeat (2) step(0, 0, 1);
    repeat (9) step(0, 0, 1);

    // blink pattern with ignored day ticks, then day wrap and mode/up collision
    goto_mode(0);
    goto_mode(1);
    repeat (10) step(1, 0, 0);
    goto_mode(0);
    set_date(4, 30);
    goto_mode(2);
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 0);

    // randomized operation
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);

    // asynchronous reset between edges while setting the day
    goto_mode(1);
    step(0, 0, 1);
    goto_mode(2);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clk_out);
    tick_day = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
    @(posedge clk_out);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    model_reset();
    #1;
    rst_n = 1'b1;
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_out);
    #3;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries still queued, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
